ocm_dual_master_arbiter: RTL
============================

# ocm_dual_master_arbiter

Shares the single-port on-chip memory (2048 x 32, byte-enabled, one-cycle read latency) between the two Nios CPU data masters of the dual-processor FIFO system. The arbiter sits between the two Avalon-MM masters and the OCM slave port. It grants one transfer per cycle using round-robin priority. A master can hold a lock across consecutive transfers to make read-modify-write atomic; a timeout bounds how long the lock can be held.

## Interface
Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LOCK_TIMEOUT, 16, idle cycles after which a held lock is forcibly released (min 1)

Ports:
- clk  in  1  single system clock
- reset_n  in  1  synchronous, active-low reset
- mK_address  in  ADDR_W  master K word address (K = 0, 1)
- mK_byteenable  in  DATA_W/8  master K byte lanes
- mK_read  in  1  master K read request
- mK_write  in  1  master K write request
- mK_writedata  in  DATA_W  master K write data
- mK_lock  in  1  keep ownership after this transfer
- mK_waitrequest  out  1  high = request not accepted this cycle
- mK_readdata  out  DATA_W  read return data (mem_readdata fanned out)
- mK_readdatavalid  out  1  one-cycle strobe, mK_readdata valid
- mem_address  out  ADDR_W  to OCM
- mem_byteenable  out  DATA_W/8  to OCM
- mem_chipselect  out  1  to OCM
- mem_write  out  1  to OCM
- mem_writedata  out  DATA_W  to OCM
- mem_clken  out  1  OCM clock enable; low only while reset_n low
- mem_readdata  in  DATA_W  from OCM, valid one cycle after the read command
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- A request is mK_read | mK_write. Asserting read and write together is illegal; the arbiter treats it as a write.
- Each cycle, at most one request wins. The winner's command drives the mem_* outputs combinationally in the same cycle, and its mK_waitrequest is 0. The loser's waitrequest is 1.
- With no requests: mem_chipselect = 0, mem_write = 0, and mem_* address/data hold the last values.
- Round robin: a 1-bit priority pointer names the preferred master. After every accepted transfer, the pointer is set to the other master. With a single requester, that requester wins regardless of the pointer.
- FSM (state in ocm_arb_pkg):
  - ARB: normal round robin. An accepted transfer with mK_lock = 1 moves to LOCK_K.
  - LOCK_K: only master K can be granted. An accepted transfer by K with lock = 0 returns to ARB. Each cycle K issues no request increments the idle counter; any K request clears it. When the counter reaches LOCK_TIMEOUT, the FSM returns to ARB, pulses lock_timeout, and sets the pointer to the other master.
- Read return: a 1-bit owner register and a valid register capture {winner, accepted read} and produce mK_readdatavalid for that owner in the following cycle. mK_readdata = mem_readdata for both masters; only the valid strobe is steered.
- Masters must hold their request stable while waitrequest = 1 (Avalon rule). The arbiter does not latch pending commands.

## Timing
- Reset values: FSM = ARB, pointer = master 0, idle counter = 0, mK_readdatavalid = 0, lock_timeout = 0.
- While reset_n = 0: both mK_waitrequest = 1, mem_chipselect = 0, mem_clken = 0.
- Write accepted in cycle N: memory updated at the clk edge ending cycle N; zero added latency.
- Read accepted in cycle N: readdatavalid high in cycle N+1. Back-to-back reads from alternating masters sustain one transfer per cycle.
- Simultaneous requests from both masters in ARB: the pointer's master wins. Continuous requests from both alternate 0,1,0,1...
- A timeout and a K request in the same cycle: the request wins. The counter is cleared and no timeout occurs.
- Reset asserted mid-read: a pending readdatavalid is dropped (not issued in the next cycle), and the lock is cleared.

## Structure
- ocm_arb_pkg: state enum {ARB, LOCK0, LOCK1}, ADDR_W/DATA_W defaults, and a master-index type.
- Sub-module ocm_rr_pick: a 2-way combinational picker (req[1:0], ptr) -> grant[1:0], one-hot or zero.
- Top level holds the FSM, pointer, idle counter ($clog2(LOCK_TIMEOUT+1) bits), return-owner pipeline register, and the mem_* mux.

## Test plan
- Only m0 writes 0xDEADBEEF to 0x010 (byteenable 4'hF), then reads 0x010 → m0_waitrequest = 0 both cycles; m0_readdatavalid high one cycle after the read with readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- Right after reset, both masters read continuously (m0 addr 0x001, m1 addr 0x002, preloaded 0x11/0x22) → grants m0, m1, m0, m1...; each master's valid strobe carries its own word.
- m0 issues a locked read of 0x020, then an unlocked write, with 3 idle cycles between them; m1 requests throughout → m1_waitrequest stays 1 until the cycle after m0's unlocked write; no timeout.
- LOCK_TIMEOUT = 4: m0 issues a locked write and then goes idle while m1 requests → lock_timeout pulses exactly 4 idle cycles later; m1 is granted the next cycle.
- m1 writes 0x0000AB00 with byteenable 4'b0010 over a word holding 0x12345678 → readback 0x1234AB78.
- reset_n low in the cycle after a granted m1 read → m1_readdatavalid never asserts; after release, a simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/ocm_arb_pkg.sv
// Shared types for the dual-master on-chip-memory arbiter: FSM states, default widths
// and the master index type.
package ocm_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef logic master_idx_t;

    function automatic arb_state_t lock_state(input master_idx_t m);
        return m ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/ocm_rr_pick.sv
// Two-way combinational round-robin picker: a lone requester always wins, and a tie
// goes to the master named by ptr. The grant is one-hot or zero.
module ocm_rr_pick
    import ocm_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t ptr,
    output logic [1:0]  grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ocm_dual_master_arbiter.sv
// Round-robin arbiter sharing one single-port OCM between two Avalon-MM masters, with
// lock-based atomic sequences, a lock idle timeout and steering of the read-return strobe.
module ocm_dual_master_arbiter
    import ocm_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                lock_timeout,
    output logic [1:0]          state_dbg
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    // Handshake: a master's command is taken in the cycle its request is high and its
    // waitrequest is low; while waitrequest is high the master holds the command unchanged.
    arb_state_t        state, state_nxt;
    master_idx_t       ptr, ptr_nxt, rd_owner, winner, lock_owner;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_nxt;
    logic              timeout_nxt, rd_valid, accept;
    logic [1:0]        req_raw, req_elig, grant;
    logic [ADDR_W-1:0] win_addr, last_addr;
    logic [BE_W-1:0]   win_be, last_be;
    logic [DATA_W-1:0] win_data, last_data;
    logic              win_write, win_lock;

    assign req_raw    = {m1_read | m1_write, m0_read | m0_write};
    assign lock_owner = (state == LOCK1);

    always_comb begin
        req_elig = 2'b00;
        if (reset_n) begin
            case (state)
                ARB:     req_elig = req_raw;
                LOCK0:   req_elig = {1'b0, req_raw[0]};
                LOCK1:   req_elig = {req_raw[1], 1'b0};
                default: req_elig = 2'b00;
            endcase
        end
    end

    ocm_rr_pick u_pick (
        .req   (req_elig),
        .ptr   (ptr),
        .grant (grant)
    );

    assign accept    = |grant;
    assign winner    = grant[1];
    // Read and write asserted together fall through as a write.
    assign win_write = winner ? m1_write      : m0_write;
    assign win_lock  = winner ? m1_lock       : m0_lock;
    assign win_addr  = winner ? m1_address    : m0_address;
    assign win_be    = winner ? m1_byteenable : m0_byteenable;
    assign win_data  = winner ? m1_writedata  : m0_writedata;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        idle_cnt_nxt = idle_cnt;
        timeout_nxt  = 1'b0;
        if (accept) begin
            ptr_nxt = ~winner;
        end
        case (state)
            ARB: begin
                idle_cnt_nxt = '0;
                if (accept && win_lock) begin
                    state_nxt = lock_state(winner);
                end
            end
            LOCK0, LOCK1: begin
                if (req_raw[lock_owner]) begin
                    idle_cnt_nxt = '0;
                    if (accept && !win_lock) begin
                        state_nxt = ARB;
                    end
                end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    // This idle cycle is the LOCK_TIMEOUT-th in a row: drop the lock.
                    state_nxt    = ARB;
                    idle_cnt_nxt = '0;
                    timeout_nxt  = 1'b1;
                    ptr_nxt      = ~lock_owner;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ARB;
            ptr          <= 1'b0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
            rd_valid     <= 1'b0;
            rd_owner     <= 1'b0;
            last_addr    <= '0;
            last_be      <= '0;
            last_data    <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            idle_cnt     <= idle_cnt_nxt;
            lock_timeout <= timeout_nxt;
            rd_valid     <= accept & ~win_write;
            rd_owner     <= winner;
            if (accept) begin
                last_addr <= win_addr;
                last_be   <= win_be;
                last_data <= win_data;
            end
        end
    end

    assign mem_address    = accept ? win_addr : last_addr;
    assign mem_byteenable = accept ? win_be   : last_be;
    assign mem_writedata  = accept ? win_data : last_data;
    assign mem_chipselect = accept;
    assign mem_write      = accept & win_write;
    assign mem_clken      = reset_n;

    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];
    assign m0_readdata    = mem_readdata;
    assign m1_readdata    = mem_readdata;
    // Gating with reset_n drops a return strobe whose read was cut off by reset.
    assign m0_readdatavalid = reset_n & rd_valid & ~rd_owner;
    assign m1_readdatavalid = reset_n & rd_valid & rd_owner;
    assign state_dbg        = state;

endmodule
